// File: rtl/sata_pkg.sv
// Shared constants and arbiter state encoding for the HBA TX FIS arbiter.
package sata_pkg;

    localparam int FIS_DW = 32;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_XFER  = 2'd1;
    localparam arb_state_t ST_ABORT = 2'd2;
    localparam arb_state_t ST_WAIT  = 2'd3;

endpackage

// File: rtl/sata_xfis_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(NREQ);

    logic [2*NREQ-1:0] req2_s;
    logic [NREQ-1:0]   rot_s;
    logic [IDXW-1:0]   pick_s;
    logic [IDXW:0]     sum_s;
    logic [IDXW:0]     wrap_s;

    assign req2_s = {req_i, req_i};
    assign rot_s  = NREQ'(req2_s >> ptr_i);

    // Lowest set offset in the rotated request vector.
    always_comb begin
        pick_s = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                pick_s = IDXW'(i);
            end else begin
                pick_s = pick_s;
            end
        end
    end

    assign sum_s  = {1'b0, ptr_i} + {1'b0, pick_s};
    assign wrap_s = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
    assign idx_o  = wrap_s[IDXW-1:0];
    assign any_o  = |req_i;
    assign gnt_o  = any_o ? (NREQ'(1'b1) << idx_o) : '0;

endmodule

// File: rtl/sata_xfis_arbiter.sv
// Shares the single HBA TX FIS stream between NREQ requesters, whole FIS at a time,
// and routes the HBA's done/err status back to the requester that owned the FIS.
module sata_xfis_arbiter
    import sata_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1000000
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic                                      link_initialized,
    input  logic [NREQ-1:0]                           req_tvalid,
    input  logic [NREQ-1:0]                           req_tlast,
    input  logic [NREQ*32-1:0]                        req_tdata,
    output logic [NREQ-1:0]                           req_tready,
    output logic [NREQ-1:0]                           req_done,
    output logic [NREQ-1:0]                           req_err,
    output logic                                      xfis_tvalid,
    output logic                                      xfis_tlast,
    output logic [31:0]                               xfis_tdata,
    input  logic                                      xfis_tready,
    input  logic                                      xfis_done,
    input  logic                                      xfis_err,
    output logic                                      busy,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(TIMEOUT) + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

    arb_state_t       state_q, state_d;
    logic [IDXW-1:0]  owner_q, owner_d;
    logic [NREQ-1:0]  owner_oh_q, owner_oh_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [NREQ-1:0]   arb_gnt_s;
    logic [IDXW-1:0]   arb_idx_s;
    logic              arb_any_s;
    logic              own_valid_s;
    logic              own_last_s;
    logic [FIS_DW-1:0] own_data_s;
    logic [IDXW-1:0]   next_ptr_s;
    logic              wait_fail_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .req_i (req_tvalid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt_s),
        .idx_o (arb_idx_s),
        .any_o (arb_any_s)
    );

    // Owner's stream selected by the registered one-hot grant; non-owner data never passes.
    always_comb begin
        own_valid_s = 1'b0;
        own_last_s  = 1'b0;
        own_data_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_oh_q[i]) begin
                own_valid_s = req_tvalid[i];
                own_last_s  = req_tlast[i];
                own_data_s  = req_tdata[i*FIS_DW +: FIS_DW];
            end else begin
                own_valid_s = own_valid_s;
            end
        end
    end

    assign next_ptr_s  = (owner_q == LAST_IDX) ? '0 : (owner_q + IDXW'(1));
    assign wait_fail_s = xfis_err | ~link_initialized | (cnt_q == CNT_LAST);

    // Next-state, stream pass-through and completion routing.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        owner_oh_d  = owner_oh_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        xfis_tvalid = 1'b0;
        xfis_tlast  = 1'b0;
        xfis_tdata  = '0;
        req_tready  = '0;
        req_done    = '0;
        req_err     = '0;
        case (state_q)
            ST_IDLE: begin
                if (link_initialized && arb_any_s) begin
                    state_d    = ST_XFER;
                    owner_d    = arb_idx_s;
                    owner_oh_d = arb_gnt_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                xfis_tvalid = own_valid_s;
                xfis_tlast  = own_last_s;
                xfis_tdata  = own_data_s;
                req_tready  = xfis_tready ? owner_oh_q : '0;
                // A completing tlast beat wins over a simultaneous link drop; WAIT then reports it.
                if (own_valid_s && xfis_tready && own_last_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (!link_initialized) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_ABORT: begin
                req_tready = owner_oh_q;
                if (own_valid_s && own_last_s) begin
                    req_err = owner_oh_q;
                    state_d = ST_IDLE;
                    ptr_d   = next_ptr_s;
                end else begin
                    state_d = ST_ABORT;
                end
            end
            ST_WAIT: begin
                if (wait_fail_s) begin
                    req_err = owner_oh_q;
                    state_d = ST_IDLE;
                    ptr_d   = next_ptr_s;
                    cnt_d   = '0;
                end else if (xfis_done) begin
                    req_done = owner_oh_q;
                    state_d  = ST_IDLE;
                    ptr_d    = next_ptr_s;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, ownership, round-robin pointer and timeout counter registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            owner_oh_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign grant_id = owner_q;

endmodule
